score_display_driver: RTL

//  Display-side consumer of the game score. Takes the binary score from the score counter,

---
 rtl/score_display_driver.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/score_display_driver.sv
// Binary score -> BCD (double-dabble FSM) -> 4-digit multiplexed 7-segment drive.
// Latency: display regs update SCORE_W+1 cycles after a change is sampled; segment/anode outputs are registered (+1 cycle).
// Backpressure: none; score changes seen while converting are dropped, and the final value is picked up on return to IDLE.
module score_display_driver #(
  parameter int SCORE_W     = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 250
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [SCORE_W-1:0] SCORE_IN,
  input  logic               GAME_WON,
  output logic               CONV_BUSY,
  output logic [1:0]         STROBE_COUNT,
  output logic [3:0]         SEG_SELECT,
  output logic [7:0]         HEX_OUT
);

  localparam int PW = $clog2(REFRESH_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int IW = $clog2(SCORE_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD} state_t;

  logic [PW-1:0]      presc;
  logic               tick;
  state_t             state, state_n;
  logic [SCORE_W-1:0] shreg, shreg_n, last_conv, last_conv_n;
  logic [11:0]        bcd, bcd_n, bcd_adj;
  logic [IW-1:0]      iter, iter_n;
  logic [3:0]         disp_h, disp_t, disp_u, disp_h_n, disp_t_n, disp_u_n;
  logic [BW-1:0]      blink_cnt;
  logic               blink_on;
  logic [3:0]         digit;
  logic               shown;

  assign tick      = (presc == PW'(REFRESH_DIV - 1));
  assign CONV_BUSY = (state != S_IDLE);

  // Refresh prescaler: one-cycle tick every REFRESH_DIV cycles.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) presc <= '0;
    else if (tick) presc <= '0;
    else presc <= presc + 1'b1;
  end

  // Digit strobe advances once per refresh tick and wraps naturally 3->0.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) STROBE_COUNT <= 2'd0;
    else if (tick) STROBE_COUNT <= STROBE_COUNT + 2'd1;
  end

  // Conversion FSM state and datapath registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      shreg     <= '0;
      last_conv <= '0;
      bcd       <= '0;
      iter      <= '0;
      disp_h    <= '0;
      disp_t    <= '0;
      disp_u    <= '0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      last_conv <= last_conv_n;
      bcd       <= bcd_n;
      iter      <= iter_n;
      disp_h    <= disp_h_n;
      disp_t    <= disp_t_n;
      disp_u    <= disp_u_n;
    end
  end

  // Next-state logic: add-3 correction on every nibble >= 5, then shift one score bit in.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    last_conv_n = last_conv;
    bcd_n       = bcd;
    iter_n      = iter;
    disp_h_n    = disp_h;
    disp_t_n    = disp_t;
    disp_u_n    = disp_u;
    bcd_adj     = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    case (state)
      S_IDLE: begin
        if (SCORE_IN != last_conv) begin
          shreg_n     = SCORE_IN;
          last_conv_n = SCORE_IN;
          bcd_n       = '0;
          iter_n      = '0;
          state_n     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {bcd_n, shreg_n} = {bcd_adj[10:0], shreg, 1'b0};
        iter_n = iter + 1'b1;
        if (iter == IW'(SCORE_W - 1)) state_n = S_LOAD;
      end
      S_LOAD: begin
        disp_h_n = bcd[11:8];
        disp_t_n = bcd[7:4];
        disp_u_n = bcd[3:0];
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Blink: count ticks while won, toggle phase every BLINK_DIV ticks; otherwise hold phase ON.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!GAME_WON) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Digit select with leading-zero blanking; units always shown, digit 3 never.
  always_comb begin
    digit = disp_u;
    shown = 1'b0;
    case (STROBE_COUNT)
      2'd0: begin digit = disp_u; shown = 1'b1; end
      2'd1: begin digit = disp_t; shown = (disp_h != 4'd0) || (disp_t != 4'd0); end
      2'd2: begin digit = disp_h; shown = (disp_h != 4'd0); end
      default: begin digit = disp_u; shown = 1'b0; end
    endcase
  end

  // Registered anode/segment drive; blanked digits and blink-off phase drive everything high.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      SEG_SELECT <= 4'b1111;
      HEX_OUT    <= 8'hFF;
    end else if (shown && blink_on) begin
      SEG_SELECT <= ~(4'b0001 << STROBE_COUNT);
      HEX_OUT    <= {1'b1, seg7(digit)};
    end else begin
      SEG_SELECT <= 4'b1111;
      HEX_OUT    <= 8'hFF;
    end
  end

endmodule
